// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM state encoding,
// the default operand width and the iteration counter sizing.
package seq_divider_pkg;

  localparam int DIV_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Combinational add/subtract y = a + (b ^ {N{sub}}) + sub, built as a
// Kogge-Stone carry-lookahead so the carry path is logarithmic in N.
module seq_divider_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_y
);

  logic [N-1:0] w_beff;
  logic [N-1:0] w_half;
  logic [N-1:0] w_gen;
  logic [N-1:0] w_prop;
  logic [N-1:0] w_gnext;
  logic [N-1:0] w_pnext;
  logic [N-1:0] w_carry;

  // The carry-in is folded into bit 0's generate, so after the prefix tree
  // w_gen[i] is the carry out of bit i.
  always_comb begin
    w_beff   = i_b ^ {N{i_sub}};
    w_half   = i_a ^ w_beff;
    w_gen    = i_a & w_beff;
    w_gen[0] = w_gen[0] | (w_half[0] & i_sub);
    w_prop   = w_half;
    w_gnext  = '0;
    w_pnext  = '0;
    for (int s = 1; s < N; s = s * 2) begin
      w_gnext = w_gen;
      w_pnext = w_prop;
      for (int i = s; i < N; i++) begin
        w_gnext[i] = w_gen[i] | (w_prop[i] & w_gen[i-s]);
        w_pnext[i] = w_prop[i] & w_prop[i-s];
      end
      w_gen  = w_gnext;
      w_prop = w_pnext;
    end
    w_carry = {w_gen[N-2:0], i_sub};
    o_y     = w_half ^ w_carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 non-restoring divider serving DIV/DIVU/REM/REMU.
// Signed operations divide magnitudes and fix up the signs at the end.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);
  localparam int N  = WIDTH + 1;

  div_state_t r_state;
  div_state_t w_next;

  logic [N-1:0]     r_p;
  logic [N-1:0]     r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_negq;
  logic             r_negr;
  logic             r_dbz;

  logic [N-1:0]     w_step_a;
  logic             w_step_sub;
  logic [N-1:0]     w_step_y;
  logic [WIDTH-1:0] w_nega_in;
  logic [WIDTH-1:0] w_nega_y;
  logic [WIDTH-1:0] w_negb_in;
  logic [WIDTH-1:0] w_negb_y;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_zero;
  logic             w_dvd_neg;
  logic             w_dvs_neg;

  assign w_zero    = (divisor == '0);
  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One shared step adder: iterate in RUN, add D back to a negative P in FIX.
  always_comb begin
    w_step_a   = {r_p[N-2:0], r_q[WIDTH-1]};
    w_step_sub = ~r_p[N-1];
    if (r_state == S_FIX) begin
      w_step_a   = r_p;
      w_step_sub = 1'b0;
    end
  end

  assign w_rem_fix = r_p[N-1] ? w_step_y[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_nega_in = (r_state == S_IDLE) ? dividend : r_q;
  assign w_negb_in = (r_state == S_IDLE) ? divisor  : w_rem_fix;

  seq_divider_addsub #(.N(N)) u_step (
    .i_a   (w_step_a),
    .i_b   (r_d),
    .i_sub (w_step_sub),
    .o_y   (w_step_y)
  );

  // Negators take operand magnitudes in IDLE and apply result signs in FIX.
  seq_divider_addsub #(.N(WIDTH)) u_nega (
    .i_a   ('0),
    .i_b   (w_nega_in),
    .i_sub (1'b1),
    .o_y   (w_nega_y)
  );

  seq_divider_addsub #(.N(WIDTH)) u_negb (
    .i_a   ('0),
    .i_b   (w_negb_in),
    .i_sub (1'b1),
    .o_y   (w_negb_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p    <= '0;
      r_d    <= '0;
      r_q    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_p    <= '0;
              r_q    <= w_dvd_neg ? w_nega_y : dividend;
              r_d    <= {1'b0, (w_dvs_neg ? w_negb_y : divisor)};
              r_cnt  <= CW'(WIDTH);
              r_negq <= w_dvd_neg ^ w_dvs_neg;
              r_negr <= w_dvd_neg;
            end
          end
        end
        S_RUN: begin
          r_p   <= w_step_y;
          r_q   <= {r_q[WIDTH-2:0], ~w_step_y[N-1]};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quot <= r_negq ? w_nega_y : r_q;
          r_rem  <= r_negr ? w_negb_y : w_rem_fix;
          r_dbz  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus a random
// sweep checked against a plain-arithmetic / and % reference model.
module tb_seq_divider;

  localparam int WIDTH = 32;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;
  localparam logic [31:0] MAX_VAL = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checkCount = 0;
  int errorCount = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: integer division truncating toward zero, done in 64 bits so
  // that MIN / -1 simply wraps to MIN when truncated back to 32 bits.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = MIN_VAL;
      4: v = MAX_VAL;
      5: v = 32'($urandom_range(0, 20));
      6: v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Starts one operation at the current negedge and observes it cycle by
  // cycle; returns in the cycle after done so a new start is accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               output logic [31:0] q, output logic [31:0] r, output logic z,
                               output int doneCyc, output int busyCnt, output logic doneAfter);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    doneCyc   = -1;
    busyCnt   = 0;
    q = '0;
    r = '0;
    z = 1'b0;
    for (int n = 1; n <= 100 && doneCyc < 0; n++) begin
      @(negedge clk);
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      if (busy) busyCnt++;
      if (done) begin
        doneCyc = n;
        q = quotient;
        r = remainder;
        z = div_by_zero;
      end
    end
    @(negedge clk);
    doneAfter = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_hold: got busy=%b done=%b q=%h r=%h z=%b, expected all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_release: got busy=%b done=%b q=%h r=%h z=%b, expected all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_unsigned_basic();
    logic [31:0] q, r;
    logic z, da;
    int lat, bc;
    applyStimulus(32'd100, 32'd7, 1'b0, q, r, z, lat, bc, da);
    checkCount++;
    if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL unsigned_100_7: got q=%0d r=%0d z=%b, expected q=14 r=2 z=0", q, r, z);
    end
    checkCount++;
    if (lat != 34 || bc != 33 || da !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL unsigned_timing: got done_cycle=%0d busy_cycles=%0d done_after=%b, expected 34 33 0",
               lat, bc, da);
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [3] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
    logic [31:0] vb [3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] eq [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] er [3] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] q, r;
    logic z, da;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(va[i], vb[i], 1'b1, q, r, z, lat, bc, da);
      checkCount++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat != 34) begin
        errorCount++;
        $display("[TB] FAIL signed_%0d: %h/%h got q=%h r=%h z=%b lat=%0d, expected q=%h r=%h z=0 lat=34",
                 i, va[i], vb[i], q, r, z, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va [5] = '{MIN_VAL, 32'hFFFF_FFFF, MIN_VAL, MAX_VAL, MIN_VAL};
    logic [31:0] vb [5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, MIN_VAL, 32'd1};
    logic        vs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] eq [5] = '{MIN_VAL, 32'hFFFF_FFFF, 32'd0, 32'd0, MIN_VAL};
    logic [31:0] er [5] = '{32'd0, 32'd0, MIN_VAL, MAX_VAL, 32'd0};
    logic [31:0] q, r;
    logic z, da;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(va[i], vb[i], vs[i], q, r, z, lat, bc, da);
      checkCount++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat != 34) begin
        errorCount++;
        $display("[TB] FAIL corner_%0d: %h/%h s=%b got q=%h r=%h z=%b lat=%0d, expected q=%h r=%h z=0 lat=34",
                 i, va[i], vb[i], vs[i], q, r, z, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] va [3] = '{32'd5, 32'd5, 32'hFFFF_FFFB};
    logic        vs [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] q, r;
    logic z, da;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(va[i], 32'd0, vs[i], q, r, z, lat, bc, da);
      checkCount++;
      if (q !== 32'hFFFF_FFFF || r !== va[i] || z !== 1'b1 || lat != 1 || bc != 0 || da !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL div_zero_%0d: got q=%h r=%h z=%b lat=%0d busy=%0d, expected q=ffffffff r=%h z=1 lat=1 busy=0",
                 i, q, r, z, lat, bc, va[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int doneCnt = 0;
    int firstDone = -1;
    logic [31:0] q = '0;
    logic [31:0] r = '0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    start     = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (firstDone < 0) begin
          firstDone = n;
          q = quotient;
          r = remainder;
        end
      end
      start     = (n == 5 || n == 20 || n == 34);
      dividend  = start ? 32'd50 : $urandom;
      divisor   = start ? 32'd5 : $urandom;
      is_signed = start;
    end
    start = 1'b0;
    checkCount++;
    if (doneCnt != 1 || firstDone != 34) begin
      errorCount++;
      $display("[TB] FAIL restart_ignored: got dones=%0d first=%0d, expected dones=1 first=34",
               doneCnt, firstDone);
    end
    checkCount++;
    if (q !== 32'd333 || r !== 32'd1) begin
      errorCount++;
      $display("[TB] FAIL restart_result: got q=%0d r=%0d, expected q=333 r=1", q, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r, eq, er;
    logic z, ez, da;
    int lat, bc;
    applyStimulus(32'd1000, 32'd3, 1'b0, q, r, z, lat, bc, da);
    applyStimulus(32'd123456, 32'hFFFF_FCEB, 1'b1, q, r, z, lat, bc, da);
    refDiv(32'd123456, 32'hFFFF_FCEB, 1'b1, eq, er, ez);
    checkCount++;
    if (q !== eq || r !== er || z !== ez || lat != 34 || bc != 33) begin
      errorCount++;
      $display("[TB] FAIL back_to_back: got q=%h r=%h z=%b lat=%0d busy=%0d, expected q=%h r=%h z=%b lat=34 busy=33",
               q, r, z, lat, bc, eq, er, ez);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] q, r;
    logic z, da;
    int lat, bc;
    int lateDone = 0;
    applyStimulus(32'd77, 32'd5, 1'b0, q, r, z, lat, bc, da);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkCount++;
    if (busy !== 1'b1 || quotient !== 32'd15) begin
      errorCount++;
      $display("[TB] FAIL midop_precondition: got busy=%b q=%0d, expected busy=1 q=15", busy, quotient);
    end
    reset_n = 1'b0;
    #1;
    checkCount++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      errorCount++;
      $display("[TB] FAIL midop_reset: got busy=%b done=%b q=%h r=%h z=%b, expected all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) lateDone++;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) lateDone++;
    end
    checkCount++;
    if (lateDone != 0) begin
      errorCount++;
      $display("[TB] FAIL midop_no_done: got %0d cycles with done/busy, expected 0", lateDone);
    end
    applyStimulus(32'd9, 32'd3, 1'b0, q, r, z, lat, bc, da);
    checkCount++;
    if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat != 34) begin
      errorCount++;
      $display("[TB] FAIL after_reset_9_3: got q=%0d r=%0d z=%b lat=%0d, expected q=3 r=0 z=0 lat=34",
               q, r, z, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic s, z, ez, da;
    int lat, bc, elat, ebc;
    for (int i = 0; i < 1200; i++) begin
      a = pickOperand();
      b = pickOperand();
      s = 1'($urandom_range(0, 1));
      refDiv(a, b, s, eq, er, ez);
      elat = ez ? 1 : 34;
      ebc  = ez ? 0 : 33;
      applyStimulus(a, b, s, q, r, z, lat, bc, da);
      checkCount++;
      if (q !== eq || r !== er || z !== ez || lat != elat || bc != ebc || da !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL random_%0d: %h/%h s=%b got q=%h r=%h z=%b lat=%0d busy=%0d, expected q=%h r=%h z=%b lat=%0d busy=%0d",
                 i, a, b, s, q, r, z, lat, bc, eq, er, ez, elat, ebc);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_overflow();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
